// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and constants for the memory port arbiter.
// Revision : 1.0
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic REQ_CPU   = 1'b0;
  localparam logic REQ_DBG   = 1'b1;
  localparam int   LAT_CNT_W = 3;

endpackage
`default_nettype wire

// File: rtl/arb_pick2.sv
`default_nettype none
// ============================================================================
// Module   : arb_pick2
// Purpose  : Two-way grant selection; round-robin when ARB_ROUND_ROBIN_EN is
//            defined, otherwise fixed priority with dbg winning ties.
// Revision : 1.0
// ============================================================================
module arb_pick2 (
  input  logic cpu_req,
  input  logic dbg_req,
  input  logic last_grant,
  output logic grant_id
);
  import mem_arb_pkg::*;

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    if (cpu_req && dbg_req) begin
      grant_id = (last_grant == REQ_CPU) ? REQ_DBG : REQ_CPU;
    end else if (dbg_req) begin
      grant_id = REQ_DBG;
    end else begin
      grant_id = REQ_CPU;
    end
  end
`else
  // Pointer has no meaning under fixed priority.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant_id = dbg_req ? REQ_DBG : REQ_CPU;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port synchronous memory between the CPU datapath
//            and the debug loader. ARB_ROUND_ROBIN_EN selects round-robin.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_done,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  import mem_arb_pkg::*;

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LAT - 1);

  state_t               state_q, state_d;
  logic                 grant_q, grant_d;
  logic [LAT_CNT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic                 mem_en_q, mem_en_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
  logic                 cpu_done_q, cpu_done_d;
  logic                 dbg_done_q, dbg_done_d;
  logic [DATA_W-1:0]    cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]    dbg_rdata_q, dbg_rdata_d;
  logic                 pick_id;
  logic                 last_grant;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == IDLE && (cpu_req || dbg_req)) begin
      last_grant_d = pick_id;
    end
  end

  // Starting from "dbg was last" makes the CPU win the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= REQ_DBG;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = REQ_DBG;
`endif

  arb_pick2 u_pick (
    .cpu_req    (cpu_req),
    .dbg_req    (dbg_req),
    .last_grant (last_grant),
    .grant_id   (pick_id)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    lat_cnt_d   = lat_cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_done_d  = 1'b0;
    dbg_done_d  = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          state_d  = ISSUE;
          grant_d  = pick_id;
          mem_en_d = 1'b1;
          if (pick_id == REQ_DBG) begin
            mem_we_d    = dbg_we;
            mem_addr_d  = dbg_addr;
            mem_wdata_d = dbg_wdata;
          end else begin
            mem_we_d    = cpu_we;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
          end
        end
      end
      ISSUE: begin
        if (mem_we_q) begin
          state_d    = DONE;
          cpu_done_d = (grant_q == REQ_CPU);
          dbg_done_d = (grant_q == REQ_DBG);
        end else begin
          state_d   = WAIT;
          lat_cnt_d = LAT_LOAD;
        end
      end
      WAIT: begin
        if (lat_cnt_q == '0) begin
          state_d    = DONE;
          cpu_done_d = (grant_q == REQ_CPU);
          dbg_done_d = (grant_q == REQ_DBG);
          if (grant_q == REQ_DBG) begin
            dbg_rdata_d = mem_rdata;
          end else begin
            cpu_rdata_d = mem_rdata;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= REQ_CPU;
      lat_cnt_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_done_q  <= 1'b0;
      dbg_done_q  <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      lat_cnt_q   <= lat_cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_done_q  <= cpu_done_d;
      dbg_done_q  <= dbg_done_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_done  = cpu_done_q;
  assign dbg_done  = dbg_done_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign cpu_stall = cpu_req & ~cpu_done_q;

endmodule
`default_nettype wire
